// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the modulo counter family.
//   - cntMode_e : overflow behaviour selected by the SAT pin
//                 (CNT_WRAP = 0 wraps at terminal, CNT_SAT = 1 holds).
//   - clog2     : ceiling log2, used to size the prescaler phase register.
// ---------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cntMode_e;

  // Ceiling log2; clog2(1) = 0, clog2(3) = 2, clog2(4) = 2.
  // A fixed-bound loop keeps this usable in constant expressions.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
//   Divides the enabled clock into count steps. The phase register runs
//   0..PRESCALE-1 while EN is high and wraps back to 0; STEP is asserted in
//   the cycle the phase holds PRESCALE-1 (so with PRESCALE = 1, STEP = EN).
//   EN low freezes the phase, so a paused period resumes where it stopped.
// Ports
//   CLK   in  1  clock, rising edge
//   RST   in  1  synchronous reset, active-high, clears the phase
//   CLR   in  1  synchronous phase clear (used by parallel load)
//   EN    in  1  advance the phase this cycle
//   STEP  out 1  one-cycle step qualifier, combinational from phase and EN
// ---------------------------------------------------------------------------
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic STEP
);

  // At least one bit so PRESCALE = 1 still elaborates a legal register;
  // in that case the phase simply stays at 0 forever.
  localparam int PHASE_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PRESCALE - 1);

  logic [PHASE_W-1:0] phaseReg;
  logic [PHASE_W-1:0] phaseNext;
  logic               atLastPhase;

  assign atLastPhase = (phaseReg == LAST_PHASE);

  always_comb begin
    phaseNext = phaseReg;
    if (CLR) begin
      phaseNext = '0;
    end else if (EN) begin
      phaseNext = atLastPhase ? '0 : phaseReg + PHASE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phaseReg <= '0;
    end else begin
      phaseReg <= phaseNext;
    end
  end

  assign STEP = EN & atLastPhase;

endmodule

// File: rtl/custom_counter_mod.sv
// ---------------------------------------------------------------------------
// custom_counter_mod
//   Parametrised synchronous modulo-MODULUS counter with enable, up/down,
//   parallel load (clamped to MODULUS-1), wrap/saturate mode, a built-in
//   prescaler and a registered carry pulse for cascading digits.
//   Edge priority: RST > LOAD > step > hold.
// Parameters
//   WIDTH     COUNT / LOAD_VAL width (1..16)
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//   PRESCALE  enabled CLK cycles per count step (1..65535)
// Ports
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   EN         in   1      count enable; low freezes counter and prescaler
//   UP         in   1      1 = count up, 0 = count down
//   SAT        in   1      0 = wrap at terminal, 1 = hold at terminal
//   LOAD       in   1      synchronous parallel load strobe
//   LOAD_VAL   in   WIDTH  value loaded on LOAD (clamped)
//   CARRY_IN   in   1      cascade enable from the lower digit (tie 1 if unused)
//   COUNT      out  WIDTH  current count, registered
//   TC         out  1      terminal count for the current direction, combinational
//   CARRY_OUT  out  1      registered one-cycle pulse after every wrap
//   AT_LIMIT   out  1      registered: a saturating step was blocked at terminal
// ---------------------------------------------------------------------------
module custom_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             CARRY_IN,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             CARRY_OUT,
  output logic             AT_LIMIT
);

  // Comparisons run one bit wider than COUNT so MODULUS = 2**WIDTH needs no
  // special case: its terminal value still fits and the wrap to 0 is explicit.
  localparam logic [WIDTH:0] LAST_VAL = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH-1:0] countReg;
  logic [WIDTH-1:0] countNext;
  logic             carryReg;
  logic             carryNext;
  logic             atLimitReg;
  logic             atLimitNext;

  logic [WIDTH:0]   countWide;
  logic [WIDTH:0]   loadWide;
  logic [WIDTH-1:0] loadClamped;
  logic             atTop;
  logic             atZero;
  logic             stepOk;
  cntMode_e         mode;

  // -------------------------------------------------------------------------
  // Prescaler: only advances while this digit is both enabled and released
  // by the lower digit; a load restarts the step period from phase 0.
  // -------------------------------------------------------------------------
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (LOAD),
    .EN   (EN & CARRY_IN),
    .STEP (stepOk)
  );

  assign countWide   = {1'b0, countReg};
  assign loadWide    = {1'b0, LOAD_VAL};
  assign loadClamped = (loadWide <= LAST_VAL) ? LOAD_VAL : LAST_VAL[WIDTH-1:0];
  assign atTop       = (countWide == LAST_VAL);
  assign atZero      = (countReg == '0);
  assign mode        = cntMode_e'(SAT);

  // -------------------------------------------------------------------------
  // Next-state mux. CARRY_OUT defaults low so it is a single-cycle pulse;
  // AT_LIMIT is a level that only a moving step, a load or reset clears.
  // -------------------------------------------------------------------------
  always_comb begin
    countNext   = countReg;
    carryNext   = 1'b0;
    atLimitNext = atLimitReg;

    if (LOAD) begin
      countNext   = loadClamped;
      atLimitNext = 1'b0;
    end else if (stepOk) begin
      if (UP) begin
        if (!atTop) begin
          countNext   = WIDTH'(countWide + (WIDTH + 1)'(1));
          atLimitNext = 1'b0;
        end else begin
          case (mode)
            CNT_WRAP: begin
              countNext   = '0;
              carryNext   = 1'b1;
              atLimitNext = 1'b0;
            end
            CNT_SAT: begin
              atLimitNext = 1'b1;
            end
            default: begin
              atLimitNext = atLimitReg;
            end
          endcase
        end
      end else begin
        if (!atZero) begin
          countNext   = WIDTH'(countWide - (WIDTH + 1)'(1));
          atLimitNext = 1'b0;
        end else begin
          case (mode)
            CNT_WRAP: begin
              countNext   = LAST_VAL[WIDTH-1:0];
              carryNext   = 1'b1;
              atLimitNext = 1'b0;
            end
            CNT_SAT: begin
              atLimitNext = 1'b1;
            end
            default: begin
              atLimitNext = atLimitReg;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      countReg   <= '0;
      carryReg   <= 1'b0;
      atLimitReg <= 1'b0;
    end else begin
      countReg   <= countNext;
      carryReg   <= carryNext;
      atLimitReg <= atLimitNext;
    end
  end

  assign COUNT     = countReg;
  assign CARRY_OUT = carryReg;
  assign AT_LIMIT  = atLimitReg;

  // Terminal count follows UP immediately, independent of the clock.
  assign TC = UP ? atTop : atZero;

endmodule

// File: tb/tb_custom_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_custom_counter_mod
//   Directed vectors with hand-computed expectations for the modulo counter:
//   a WIDTH=4 / MODULUS=10 digit, a PRESCALE=3 digit and a units->tens cascade.
// ---------------------------------------------------------------------------
module tb_custom_counter_mod;

  logic clk;
  logic rst;

  // Main digit, PRESCALE = 1
  logic       aEn, aUp, aSat, aLoad, aCarryIn;
  logic [3:0] aLoadVal;
  logic [3:0] aCount;
  logic       aTc, aCarry, aAtLimit;

  // Prescaled digit, PRESCALE = 3
  logic       pEn, pUp, pSat, pLoad, pCarryIn;
  logic [3:0] pLoadVal;
  logic [3:0] pCount;
  logic       pTc, pCarry, pAtLimit;

  // Cascade: units feeds tens
  logic       cEn, cUp, cSat, cLoad, cCarryIn;
  logic [3:0] cLoadVal;
  logic [3:0] uCount, tCount;
  logic       uTc, uCarry, uAtLimit;
  logic       tTc, tCarry, tAtLimit;

  int vecCount  = 0;
  int missCount = 0;

  custom_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
    .CLK(clk), .RST(rst), .EN(aEn), .UP(aUp), .SAT(aSat), .LOAD(aLoad),
    .LOAD_VAL(aLoadVal), .CARRY_IN(aCarryIn), .COUNT(aCount), .TC(aTc),
    .CARRY_OUT(aCarry), .AT_LIMIT(aAtLimit)
  );

  custom_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dutPre (
    .CLK(clk), .RST(rst), .EN(pEn), .UP(pUp), .SAT(pSat), .LOAD(pLoad),
    .LOAD_VAL(pLoadVal), .CARRY_IN(pCarryIn), .COUNT(pCount), .TC(pTc),
    .CARRY_OUT(pCarry), .AT_LIMIT(pAtLimit)
  );

  custom_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutUnits (
    .CLK(clk), .RST(rst), .EN(cEn), .UP(cUp), .SAT(cSat), .LOAD(cLoad),
    .LOAD_VAL(cLoadVal), .CARRY_IN(cCarryIn), .COUNT(uCount), .TC(uTc),
    .CARRY_OUT(uCarry), .AT_LIMIT(uAtLimit)
  );

  custom_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutTens (
    .CLK(clk), .RST(rst), .EN(cEn), .UP(cUp), .SAT(cSat), .LOAD(cLoad),
    .LOAD_VAL(cLoadVal), .CARRY_IN(uCarry), .COUNT(tCount), .TC(tTc),
    .CARRY_OUT(tCarry), .AT_LIMIT(tAtLimit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
    end else begin
      $display("vec %0d %s: %0d ok", vecCount, tag, observed);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int expCnt;
  int tensPulses;
  int exp3Cnt[4]  = '{1, 0, 0, 0};
  int exp3Lim[4]  = '{0, 0, 1, 1};
  int exp5a[6]    = '{0, 0, 1, 1, 1, 2};
  int exp5b[3]    = '{5, 5, 6};

  initial begin
    rst = 1'b1;
    aEn = 0; aUp = 1; aSat = 0; aLoad = 0; aLoadVal = '0; aCarryIn = 1;
    pEn = 0; pUp = 1; pSat = 0; pLoad = 0; pLoadVal = '0; pCarryIn = 1;
    cEn = 0; cUp = 1; cSat = 0; cLoad = 0; cLoadVal = '0; cCarryIn = 1;

    // ---- 1: reset, including reset while counting at 7/8 ----
    tick(); tick();
    rst = 1'b0;
    checkVal("rst_count", aCount, 0);
    checkVal("rst_carry", aCarry, 0);
    checkVal("rst_limit", aAtLimit, 0);
    checkVal("rst_tc_up", aTc, 0);

    aLoad = 1; aLoadVal = 4'd7;
    tick();
    aLoad = 0;
    checkVal("load7", aCount, 7);
    aEn = 1;
    tick();
    checkVal("step8", aCount, 8);
    rst = 1'b1;
    tick();
    checkVal("midrst_count", aCount, 0);
    checkVal("midrst_carry", aCarry, 0);
    checkVal("midrst_limit", aAtLimit, 0);
    tick();
    checkVal("midrst_hold", aCount, 0);
    rst = 1'b0;

    // ---- 2: wrap counting up ----
    aUp = 1; aSat = 0; aEn = 1;
    expCnt = 0;
    for (int i = 1; i <= 10; i++) begin
      checkVal("up_tc", aTc, (expCnt == 9) ? 1 : 0);
      tick();
      expCnt = i % 10;
      checkVal("up_count", aCount, expCnt);
      checkVal("up_carry", aCarry, (i == 10) ? 1 : 0);
    end
    tick();
    checkVal("up_after_count", aCount, 1);
    checkVal("up_after_carry", aCarry, 0);

    // ---- 3: saturating count down ----
    aUp = 0; aSat = 1; aLoad = 1; aLoadVal = 4'd2;
    tick();
    aLoad = 0;
    checkVal("sat_load", aCount, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("sat_count", aCount, exp3Cnt[i]);
      checkVal("sat_limit", aAtLimit, exp3Lim[i]);
      checkVal("sat_carry", aCarry, 0);
    end
    checkVal("sat_tc_down", aTc, 1);
    aUp = 1;
    #1;
    checkVal("sat_tc_flip", aTc, 0);
    tick();
    checkVal("sat_up_count", aCount, 1);
    checkVal("sat_up_limit", aAtLimit, 0);

    // ---- 4: clamped load over a pending limit, then wraps both ways ----
    aUp = 0; aSat = 1;
    tick();
    tick();
    checkVal("pre4_count", aCount, 0);
    checkVal("pre4_limit", aAtLimit, 1);
    aUp = 1; aLoad = 1; aLoadVal = 4'd13;
    tick();
    aLoad = 0;
    checkVal("clamp_count", aCount, 9);
    checkVal("clamp_carry", aCarry, 0);
    checkVal("clamp_limit", aAtLimit, 0);
    checkVal("clamp_tc", aTc, 1);
    aSat = 0;
    tick();
    checkVal("wrap_up_count", aCount, 0);
    checkVal("wrap_up_carry", aCarry, 1);
    aUp = 0;
    tick();
    checkVal("wrap_dn_count", aCount, 9);
    checkVal("wrap_dn_carry", aCarry, 1);
    aEn = 0;
    tick();
    checkVal("en_low_count", aCount, 9);
    checkVal("en_low_carry", aCarry, 0);

    // ---- 5: prescaler, pause and load phase clear ----
    pEn = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkVal("pre_count", pCount, exp5a[i]);
    end
    tick();                         // phase 0 -> 1
    pEn = 0;
    tick(); tick();
    checkVal("pre_pause", pCount, 2);
    pEn = 1;
    tick();
    checkVal("pre_resume1", pCount, 2);
    tick();
    checkVal("pre_resume2", pCount, 3);
    tick();                         // phase 0 -> 1
    pLoad = 1; pLoadVal = 4'd5;
    tick();
    pLoad = 0;
    checkVal("pre_load", pCount, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("pre_phase", pCount, exp5b[i]);
    end

    // ---- 6: two-digit cascade ----
    cEn = 1;
    tensPulses = 0;
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (tCarry) tensPulses++;
      if (k == 55) begin
        checkVal("cas55_units", uCount, 5);
        checkVal("cas55_tens", tCount, 5);
      end
      if (k == 99) begin
        checkVal("cas99_units", uCount, 9);
        checkVal("cas99_tens", tCount, 9);
      end
      if (k == 100) begin
        checkVal("cas100_units", uCount, 0);
        checkVal("cas100_tens", tCount, 9);
      end
      if (k == 101) begin
        checkVal("cas101_tens", tCount, 0);
        checkVal("cas101_tcarry", tCarry, 1);
      end
    end
    cEn = 0;
    checkVal("cas_tens_pulses", tensPulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
